// File: rtl/alu_pkg.sv
// Shared opcode codes and iterative-unit state encoding for the EX-stage ALU.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;
   localparam logic [3:0] OP_MFHI  = 4'b1010;
   localparam logic [3:0] OP_MFLO  = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_MULTU) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider; one bit per cycle,
// results land in HI/LO only on the final iteration.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dz_q, dz_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic               rem_fits;
   logic [2*WIDTH-1:0] step;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      rem_fits = (rem_sh >= {1'b0, b_q});
      // When the shifted remainder fits, the true difference is < b, so the low bits suffice.
      rem_sub  = rem_sh[WIDTH-1:0] - b_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
      step    = '0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               b_d   = b;
               cnt_d = CNT_W'(WIDTH);
               if (is_div) begin
                  dz_d    = (b == '0);
                  // Divide-by-zero preloads the final {hi, lo} so DIV can finish at once.
                  acc_d   = (b == '0) ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a};
                  state_d = ST_DIV;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, a};
                  state_d = ST_MUL;
               end
            end
         end
         ST_MUL: begin
            step  = {mul_sum, acc_q[WIDTH-1:1]};
            acc_d = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = step[2*WIDTH-1:WIDTH];
               lo_d    = step[WIDTH-1:0];
               state_d = ST_DONE;
            end
         end
         ST_DIV: begin
            if (dz_q) begin
               hi_d    = acc_q[2*WIDTH-1:WIDTH];
               lo_d    = acc_q[WIDTH-1:0];
               state_d = ST_DONE;
            end else begin
               step  = rem_fits ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                : {acc_q[2*WIDTH-2:0], 1'b0};
               acc_d = step;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  hi_d    = step[2*WIDTH-1:WIDTH];
                  lo_d    = step[WIDTH-1:0];
                  state_d = ST_DONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   assign done = (state_q == ST_DONE);
   assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign dz   = dz_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU: registered single-cycle ops plus an iterative MULTU/DIVU unit
// behind a valid/ready handshake.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned OP_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  Signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             out_valid,
   output logic [WIDTH-1:0] dataOut,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   logic             accept, start;
   logic             md_done, md_busy, md_dz;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] res;

   logic             out_valid_q, out_valid_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] data_q, data_d;

   assign in_ready = !md_busy;
   assign accept   = in_valid && in_ready;
   assign start    = accept && is_iter_op(Signal);

   always_comb begin
      res = '0;
      case (Signal)
         OP_AND:  res = dataA & dataB;
         OP_OR:   res = dataA | dataB;
         OP_ADD:  res = dataA + dataB;
         OP_SUB:  res = dataA - dataB;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
         OP_XOR:  res = dataA ^ dataB;
         OP_NOR:  res = ~(dataA | dataB);
         OP_MFHI: res = md_hi;
         OP_MFLO: res = md_lo;
         default: res = '0;
      endcase
   end

   always_comb begin
      out_valid_d = 1'b0;
      data_d      = data_q;
      zero_d      = zero_q;
      if (md_done) begin
         data_d = md_lo;
         zero_d = (md_lo == '0);
      end
      if (accept && !is_iter_op(Signal)) begin
         out_valid_d = 1'b1;
         data_d      = res;
         zero_d      = (res == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         zero_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         zero_q      <= zero_d;
      end
   end

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (Signal == OP_DIVU),
      .a      (dataA),
      .b      (dataB),
      .done   (md_done),
      .busy   (md_busy),
      .hi     (md_hi),
      .lo     (md_lo),
      .dz     (md_dz)
   );

   // During DONE the fresh LO is shown directly; the output register captures it for holding.
   assign out_valid   = out_valid_q | md_done;
   assign dataOut     = md_done ? md_lo : data_q;
   assign zero        = md_done ? (md_lo == '0) : zero_q;
   assign hi          = md_hi;
   assign lo          = md_lo;
   assign div_by_zero = md_dz;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised check of alu_muldiv_seq against an arithmetic reference model,
// plus directed latency, stall, reset-abort and WIDTH=8 cases.
module tb_alu_muldiv_seq;

   localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_SLTU = 4'd3,
                          C_XOR = 4'd4, C_NOR = 4'd5, C_SUB = 4'd6, C_SLT = 4'd7,
                          C_MULTU = 4'd8, C_DIVU = 4'd9, C_MFHI = 4'd10, C_MFLO = 4'd11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op_i = '0;
   logic [31:0] a_i = '0, b_i = '0;
   logic        out_valid, zero, div_by_zero;
   logic [31:0] dataOut, hi, lo;

   logic        v8 = 1'b0;
   logic        r8;
   logic [3:0]  s8 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ov8, z8, dz8;
   logic [7:0]  d8, hi8, lo8;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] m_hi = '0, m_lo = '0;
   logic        m_dz = 1'b0;

   always #5 clk = ~clk;

   alu_muldiv_seq #(.WIDTH(32), .OP_W(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Signal(op_i),
      .dataA(a_i), .dataB(b_i), .out_valid(out_valid), .dataOut(dataOut), .zero(zero),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   alu_muldiv_seq #(.WIDTH(8), .OP_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .Signal(s8),
      .dataA(a8), .dataB(b8), .out_valid(ov8), .dataOut(d8), .zero(z8),
      .hi(hi8), .lo(lo8), .div_by_zero(dz8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: expected result and latency, updates architectural HI/LO/DZ.
   function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] r, output int lat);
      logic [63:0] p;
      lat = 1;
      r   = '0;
      case (op)
         C_AND:  r = a & b;
         C_OR:   r = a | b;
         C_ADD:  r = a + b;
         C_SUB:  r = a - b;
         C_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         C_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         C_XOR:  r = a ^ b;
         C_NOR:  r = ~(a | b);
         C_MFHI: r = m_hi;
         C_MFLO: r = m_lo;
         C_MULTU: begin
            p = 64'(a) * 64'(b);
            m_hi = p[63:32];
            m_lo = p[31:0];
            r = m_lo;
            lat = 33;
         end
         C_DIVU: begin
            if (b == 0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1; lat = 2;
            end else begin
               m_hi = a % b; m_lo = a / b; m_dz = 1'b0; lat = 33;
            end
            r = m_lo;
         end
         default: r = '0;
      endcase
   endfunction

   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_res;
      int e_lat, lat, rdy_hi;
      model(op, a, b, e_res, e_lat);
      @(negedge clk);
      check("ready_at_issue", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1; rdy_hi = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready) rdy_hi++;
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(e_lat));
      if (e_lat > 1) check("ready_low_busy", 64'(rdy_hi), 64'd0);
      check("dataOut", 64'(dataOut), 64'(e_res));
      check("zero", 64'(zero), 64'(e_res == 0));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dz));
      @(negedge clk);
      check("ov_pulse_end", 64'(out_valid), 64'd0);
      check("dataOut_hold", 64'(dataOut), 64'(e_res));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  t1_op [4] = '{C_ADD, C_SUB, C_SLT, C_SLTU};
      logic [31:0] t1_a  [4] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t1_b  [4] = '{32'd1, 32'd5, 32'd1, 32'd1};
      logic [31:0] t1_e  [4] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0};
      logic [31:0] e_res;
      int          e_lat, cnt, extra, lat;
      logic [3:0]  op;
      logic [31:0] ra, rb;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_dataOut", 64'(dataOut), 64'd0);
      check("rst_zero", 64'(zero), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_dz", 64'(div_by_zero), 64'd0);
      rst = 1'b0;

      // Back-to-back single-cycle ops
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_data", 64'(dataOut), 64'(t1_e[i-1]));
            check("b2b_zero", 64'(zero), 64'(t1_e[i-1] == 0));
         end
         if (i < 4) begin
            check("b2b_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1; op_i = t1_op[i]; a_i = t1_a[i]; b_i = t1_b[i];
         end else begin
            in_valid = 1'b0;
         end
      end

      // Directed multiply/divide
      do_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
      check("mul_max_lo", 64'(lo), 64'h0000_0001);
      do_op(C_DIVU, 32'd100, 32'd7);
      check("div_q", 64'(lo), 64'd14);
      check("div_r", 64'(hi), 64'd2);
      do_op(C_DIVU, 32'd5, 32'd0);
      check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
      check("div0_dz", 64'(div_by_zero), 64'd1);
      do_op(C_MULTU, 32'd0, 32'hDEAD_BEEF);
      do_op(C_MFHI, 32'd0, 32'd0);

      // MFLO held while a MULTU is in flight
      model(C_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, e_res, e_lat);
      @(negedge clk);
      in_valid = 1'b1; op_i = C_MULTU; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0;
      @(negedge clk);
      op_i = C_MFLO; a_i = $urandom; b_i = $urandom;
      cnt = 0; extra = 0;
      while (!in_ready && cnt < 100) begin
         if (out_valid) extra++;
         @(negedge clk);
         cnt++;
      end
      check("stall_cycles", 64'(cnt), 64'd32);
      check("stall_no_ov", 64'(extra), 64'd0);
      check("stall_done_ov", 64'(out_valid), 64'd1);
      check("stall_done_lo", 64'(lo), 64'(m_lo));
      @(negedge clk);
      in_valid = 1'b0;
      check("mflo_ov", 64'(out_valid), 64'd1);
      check("mflo_data", 64'(dataOut), 64'(m_lo));

      // Asynchronous reset mid-DIVU
      do_op(C_DIVU, 32'd77, 32'd0);
      @(negedge clk);
      in_valid = 1'b1; op_i = C_DIVU; a_i = 32'd1000; b_i = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_ready", 64'(in_ready), 64'd1);
      check("arst_ov", 64'(out_valid), 64'd0);
      check("arst_data", 64'(dataOut), 64'd0);
      check("arst_zero", 64'(zero), 64'd0);
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      check("arst_dz", 64'(div_by_zero), 64'd0);
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b1; op_i = C_ADD; a_i = 32'd3; b_i = 32'd4;
      @(negedge clk);
      in_valid = 1'b0;
      check("post_rst_ov", 64'(out_valid), 64'd1);
      check("post_rst_add", 64'(dataOut), 64'd7);

      // Randomised operations
      for (int n = 0; n < 80; n++) begin
         op = 4'($urandom_range(0, 15));
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: ra = 32'hFFFF_FFFF;
            2: rb = 32'($urandom_range(1, 20));
            3: ra = rb;
            default: ;
         endcase
         do_op(op, ra, rb);
      end

      // WIDTH=8 instance
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         v8 = 1'b1;
         s8 = (k == 0) ? C_MULTU : C_DIVU;
         a8 = (k == 0) ? 8'hFF : 8'd200;
         b8 = (k == 0) ? 8'h02 : 8'd13;
         @(negedge clk);
         v8 = 1'b0;
         lat = 1;
         while (!ov8 && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         check("w8_latency", 64'(lat), 64'd9);
         check("w8_hi", 64'(hi8), (k == 0) ? 64'h01 : 64'd5);
         check("w8_lo", 64'(lo8), (k == 0) ? 64'hFE : 64'd15);
         check("w8_data", 64'(d8), (k == 0) ? 64'hFE : 64'd15);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
